// File: rtl/regfile_pkg.sv
// Shared defaults and the constant-function log2 used to size register-file address ports.
package regfile_pkg;

  localparam int DEF_DATA_W       = 64;
  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_NUM_RD_PORTS = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One read port: NUM_REGS:1 selection from the flattened storage, overridden by write-through data.
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int AW      = clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [AW-1:0]              addr,
  input  logic                       byp_en,
  input  logic [DATA_W-1:0]          byp_data,
  output logic [DATA_W-1:0]          dout
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_unflat
    assign regs[r] = regs_flat[r*DATA_W +: DATA_W];
  end

  always_comb begin
    dout = regs[addr];
    if (byp_en) dout = byp_data;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Flop-based register file: one write port, NUM_RD_PORTS independent read ports with
// write-through bypass and optional registered read data.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
  parameter int ZERO_REG     = 1,
  parameter int REG_OUT      = 1,
  localparam int AW          = clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [NUM_RD_PORTS-1:0]        rd_en,
  input  logic [NUM_RD_PORTS*AW-1:0]     rd_addr,
  output logic [NUM_RD_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]        rd_valid
);

  logic [NUM_REGS*DATA_W-1:0]     regs_flat;
  logic                           wr_ok;
  logic [NUM_RD_PORTS-1:0]        byp_en;
  logic [NUM_RD_PORTS*DATA_W-1:0] sel_p0;

  // A discarded write to the hardwired zero register must not bypass either.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_flat <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && (wr_addr == AW'(r))) regs_flat[r*DATA_W +: DATA_W] <= wr_data;
      end
    end
  end

  // Stage p0: per-port selection with write-through
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    assign byp_en[p] = wr_ok && (rd_addr[p*AW +: AW] == wr_addr);

    regfile_read_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_mux (
      .regs_flat (regs_flat),
      .addr      (rd_addr[p*AW +: AW]),
      .byp_en    (byp_en[p]),
      .byp_data  (wr_data),
      .dout      (sel_p0[p*DATA_W +: DATA_W])
    );
  end

  // Stage p1: registered read data, held while the port is idle
  if (REG_OUT != 0) begin : g_reg
    logic [NUM_RD_PORTS*DATA_W-1:0] rd_data_p1;
    logic [NUM_RD_PORTS-1:0]        vld_p1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_p1 <= '0;
        vld_p1     <= '0;
      end else begin
        vld_p1 <= rd_en;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          if (rd_en[p]) rd_data_p1[p*DATA_W +: DATA_W] <= sel_p0[p*DATA_W +: DATA_W];
        end
      end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;
  end else begin : g_comb
    assign rd_data  = reset ? '0 : sel_p0;
    assign rd_valid = reset ? '0 : rd_en;
  end

endmodule
